// File: rtl/micro_op_sequencer_if.sv
// Decode-side bus between the IF/ID register, the micro-op sequencer and the control unit.
// The master drives the instruction/control inputs; the sequencer (slave) returns the decode opcode and status.
interface micro_op_sequencer_if #(
  parameter int OPC_W = 5
) ();
  logic [OPC_W-1:0] instr_opcode;
  logic             instr_valid;
  logic             int_req;
  logic             stall_in;
  logic             flush;
  logic [OPC_W-1:0] opcode_out;
  logic             fetch_stall;
  logic             seq_busy;
  logic             int_ack;

  modport master (
    output instr_opcode, instr_valid, int_req, stall_in, flush,
    input  opcode_out, fetch_stall, seq_busy, int_ack
  );

  modport slave (
    input  instr_opcode, instr_valid, int_req, stall_in, flush,
    output opcode_out, fetch_stall, seq_busy, int_ack
  );
endinterface

// File: rtl/micro_op_sequencer.sv
// Expands CALL/RET/RTI and interrupt entry into primitive stack/jump opcodes for the control unit,
// stalling fetch while a sequence runs; every other opcode passes straight through.
module micro_op_sequencer #(
  parameter int RET_BUBBLES = 2,
  parameter int OPC_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  micro_op_sequencer_if.slave  bus
);
  localparam logic [OPC_W-1:0] OP_NOP        = '0;
  localparam logic [OPC_W-1:0] OP_CALL       = OPC_W'(5'b01101);
  localparam logic [OPC_W-1:0] OP_RET        = OPC_W'(5'b01110);
  localparam logic [OPC_W-1:0] OP_RTI        = OPC_W'(5'b01111);
  localparam logic [OPC_W-1:0] OP_PUSH_PC    = OPC_W'(5'b11111);
  localparam logic [OPC_W-1:0] OP_PUSH_FLAGS = OPC_W'(5'b11110);
  localparam logic [OPC_W-1:0] OP_POP_PC     = OPC_W'(5'b11100);
  localparam logic [OPC_W-1:0] OP_POP_FLAGS  = OPC_W'(5'b11101);
  localparam logic [OPC_W-1:0] OP_JMP_CALL   = OPC_W'(5'b11011);
  localparam logic [1:0]       BUB_INIT      = 2'(RET_BUBBLES);

  typedef enum logic [2:0] {
    S_IDLE, S_CALL_JMP, S_RTI_POPPC, S_BUBBLE, S_INT_FLAGS, S_INT_VEC
  } state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_cnt, w_cnt_next;
  logic             r_int_pending, w_int_pending_next;
  logic [OPC_W-1:0] w_opc;
  logic             w_fetch_stall;
  logic             w_int_ack;
  logic             w_flushable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_int_pending <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_cnt_next;
      r_int_pending <= w_int_pending_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_cnt_next    = r_cnt;
    w_opc         = OP_NOP;
    w_fetch_stall = 1'b0;
    w_int_ack     = 1'b0;
    w_flushable   = (r_state != S_INT_FLAGS) && (r_state != S_INT_VEC);

    case (r_state)
      S_IDLE: begin
        if (r_int_pending) begin
          w_opc         = OP_PUSH_PC;
          w_fetch_stall = 1'b1;
          w_next        = S_INT_FLAGS;
        end else if (bus.instr_valid && bus.instr_opcode == OP_CALL) begin
          w_opc         = OP_PUSH_PC;
          w_fetch_stall = 1'b1;
          w_next        = S_CALL_JMP;
        end else if (bus.instr_valid && bus.instr_opcode == OP_RET) begin
          w_opc         = OP_POP_PC;
          w_fetch_stall = 1'b1;
          w_next        = (RET_BUBBLES == 0) ? S_IDLE : S_BUBBLE;
          w_cnt_next    = BUB_INIT;
        end else if (bus.instr_valid && bus.instr_opcode == OP_RTI) begin
          w_opc         = OP_POP_FLAGS;
          w_fetch_stall = 1'b1;
          w_next        = S_RTI_POPPC;
        end else begin
          w_opc = bus.instr_valid ? bus.instr_opcode : OP_NOP;
        end
      end
      S_CALL_JMP: begin
        w_opc  = OP_JMP_CALL;
        w_next = S_IDLE;
      end
      S_RTI_POPPC: begin
        w_opc         = OP_POP_PC;
        w_fetch_stall = 1'b1;
        w_next        = (RET_BUBBLES == 0) ? S_IDLE : S_BUBBLE;
        w_cnt_next    = BUB_INIT;
      end
      S_BUBBLE: begin
        w_cnt_next    = r_cnt - 2'd1;
        w_fetch_stall = (r_cnt > 2'd1);
        if (r_cnt <= 2'd1) w_next = S_IDLE;
      end
      S_INT_FLAGS: begin
        w_opc         = OP_PUSH_FLAGS;
        w_fetch_stall = 1'b1;
        w_next        = S_INT_VEC;
      end
      S_INT_VEC: begin
        w_int_ack = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // Flush beats stall, but interrupt entry is never squashed and only honours stall.
    if (bus.flush && w_flushable) begin
      w_opc         = OP_NOP;
      w_next        = S_IDLE;
      w_cnt_next    = '0;
      w_fetch_stall = 1'b0;
      w_int_ack     = 1'b0;
    end else if (bus.stall_in) begin
      w_next        = r_state;
      w_cnt_next    = r_cnt;
      w_fetch_stall = 1'b1;
      w_int_ack     = 1'b0;
    end

    w_int_pending_next = bus.int_req | (r_int_pending & ~w_int_ack);
  end

  assign bus.opcode_out  = rst_n ? w_opc : OP_NOP;
  assign bus.fetch_stall = rst_n & w_fetch_stall;
  assign bus.int_ack     = rst_n & w_int_ack;
  assign bus.seq_busy    = rst_n & (r_state != S_IDLE);
endmodule

// File: doc/micro_op_sequencer.md
Name: micro_op_sequencer

Overview:
- Sits between the IF/ID register and the decode control unit. Expands multi-step instructions CALL, RET and RTI, plus hardware interrupt entry, into sequences of primitive opcodes that the control unit already decodes: PUSH_PC, PUSH_FLAGS, POP_PC, POP_FLAGS and JMP_CALL.
- Stalls fetch while a sequence runs.
- Passes all other opcodes through unchanged with zero latency.

Parameters:
- RET_BUBBLES, 2: number of NOPs emitted after the final POP_PC of RET/RTI, covering the wait for the memory stage to return the PC. Legal range 0..3.
- OPC_W, 5: opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instr_opcode  in  5  opcode field of the instruction held in IF/ID.
- instr_valid  in  1  IF/ID holds a real instruction; when 0 it is treated as NOP.
- int_req  in  1  level interrupt request.
- stall_in  in  1  hazard-unit stall; freezes the sequencer.
- flush  in  1  branch-resolution flush of the decode stage.
- opcode_out  out  5  opcode presented to the control unit.
- fetch_stall  out  1  hold PC and IF/ID this cycle.
- seq_busy  out  1  a sequence is in progress (state != IDLE).
- int_ack  out  1  one-cycle pulse; fetch loads the interrupt vector.

Behaviour:
- Opcode encodings:
  - NOP 00000, CALL 01101, RET 01110, RTI 01111.
  - PUSH_PC 11111, PUSH_FLAGS 11110, POP_PC 11100, POP_FLAGS 11101, JMP_CALL 11011.
- Reset: when rst_n=0 at a clock edge:
  - state becomes IDLE, int_pending=0, bubble counter=0.
  - While rst_n is low: opcode_out=00000, fetch_stall=0, seq_busy=0, int_ack=0.
- int_pending:
  - Set on any cycle with int_req=1.
  - Cleared in the cycle int_ack=1.
  - The set condition wins if int_req=1 in the ack cycle. The interrupt then re-enters only after the current sequence completes.
- States: IDLE, CALL_JMP, RTI_POPPC, BUBBLE, INT_FLAGS, INT_VEC.
- IDLE, in priority order:
  1. int_pending=1: output PUSH_PC, fetch_stall=1, next state INT_FLAGS. The instruction in IF/ID is held and becomes the return point.
  2. CALL: output PUSH_PC, fetch_stall=1, next state CALL_JMP.
  3. RET: output POP_PC, fetch_stall=1, next state BUBBLE (counter=RET_BUBBLES), or IDLE if RET_BUBBLES=0.
  4. RTI: output POP_FLAGS, fetch_stall=1, next state RTI_POPPC.
  5. Otherwise: opcode_out = instr_opcode (combinational pass-through), or 00000 if instr_valid=0. fetch_stall=0.
- CALL_JMP: output JMP_CALL, fetch_stall=0, next state IDLE.
- RTI_POPPC: output POP_PC, fetch_stall=1, next state BUBBLE (or IDLE if RET_BUBBLES=0).
- BUBBLE:
  - Output NOP and decrement the counter.
  - fetch_stall=1 while counter>1. On the last bubble, fetch_stall=0 and next state is IDLE.
- INT_FLAGS: output PUSH_FLAGS, fetch_stall=1, next state INT_VEC.
- INT_VEC: output NOP, int_ack=1, fetch_stall=0, next state IDLE.
- Latency:
  - Pass-through is 0 cycles.
  - CALL occupies 2 decode slots.
  - RET occupies 1+RET_BUBBLES slots; RTI occupies 2+RET_BUBBLES slots.
  - Interrupt entry occupies 3 slots.
- stall_in=1 (and flush=0):
  - State, counter and int_pending set/clear are frozen; int_pending may still be set.
  - opcode_out holds the value for the current state.
  - fetch_stall is forced to 1 and int_ack to 0.
- flush=1 (wins over stall_in):
  - In IDLE, CALL_JMP, RTI_POPPC or BUBBLE: opcode_out=00000, next state IDLE, fetch_stall=0, counter cleared.
  - In INT_FLAGS or INT_VEC: flush is ignored, because interrupt entry is not squashable.
  - An IDLE flush with int_pending=1 still drops the current cycle's output. int_pending stays set and is taken the next cycle.
- Interrupts are never taken mid-sequence; only IDLE samples int_pending.
- Unknown or unused opcodes in IDLE pass through unchanged.

Test Plan:
- Reset and pass-through: rst_n=0 for 2 cycles, then rst_n=1 with instr_opcode=10011 (ADD), instr_valid=1 -> during reset opcode_out=00000 and all flags 0; after reset opcode_out=10011 in the same cycle, fetch_stall=0, seq_busy=0.
- CALL: present 01101 -> opcode_out 11111 then 11011 on consecutive cycles; fetch_stall 1,0; seq_busy 0,1; next cycle IDLE.
- RTI with RET_BUBBLES=2: present 01111 -> opcode_out 11101, 11100, 00000, 00000; fetch_stall 1,1,1,0. RET gives 11100, 00000, 00000 with fetch_stall 1,1,0.
- Interrupt: pulse int_req for 1 cycle during the CALL_JMP cycle -> CALL completes (11011), then 11111, 11110, 00000 with int_ack=1 only on the third step; int_pending cleared after.
- Stall and flush: stall_in=1 for 3 cycles in RTI_POPPC -> opcode_out held at 11100 and fetch_stall=1; release resumes with bubbles. flush=1 in BUBBLE -> 00000, IDLE next. flush=1 in INT_FLAGS -> ignored, 11110 still emitted.
- Reset mid-sequence: rst_n=0 while in BUBBLE with int_pending=1 -> next cycle IDLE, counter 0, int_pending 0, and pass-through resumes after release.
